// File: rtl/gemm_tile_sequencer.sv
// rtl/gemm_tile_sequencer.sv - tiled GEMM address/strobe sequencer with traversal order select and size checking
module gemm_tile_sequencer #(
    parameter int M             = 2,
    parameter int K             = 32,
    parameter int N             = 1,
    parameter int SizeAddrWidth = 8,
    parameter int AddrWidth     = 6,
    parameter int AddrWidthC    = 9
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     order_i,
    input  logic [SizeAddrWidth-1:0] M_size_i,
    input  logic [SizeAddrWidth-1:0] K_size_i,
    input  logic [SizeAddrWidth-1:0] N_size_i,
    output logic [AddrWidth-1:0]     sram_a_addr_o,
    output logic [AddrWidth-1:0]     sram_b_addr_o,
    output logic [AddrWidthC-1:0]    sram_c_addr_o,
    output logic                     sram_c_we_o,
    output logic                     mac_valid_o,
    output logic                     mac_clear_o,
    output logic                     mac_last_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o
);
    localparam int SW = SizeAddrWidth;
    localparam int PW = 2 * SW + 1;
    localparam int LM = $clog2(M);
    localparam int LK = $clog2(K);
    localparam int LN = $clog2(N);
    localparam logic [PW-1:0] LIM_A = PW'(1) << AddrWidth;
    localparam logic [PW-1:0] LIM_C = PW'(1) << AddrWidthC;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    state_t r_state, w_next;

    logic [SW-1:0]         r_mt_n, r_kt_n, r_nt_n, r_mt, r_kt, r_nt;
    logic                  r_order, r_drain, r_err;
    logic [AddrWidth-1:0]  r_a_row, r_b_kt;
    logic [AddrWidthC-1:0] r_c_row, r_c_pipe, r_c_addr;
    logic                  r_mac_valid, r_mac_clear, r_mac_last, r_c_we;

    logic [SW-1:0]         w_mt, w_kt, w_nt;
    logic [PW-1:0]         w_mk, w_kn, w_mn;
    logic                  w_size_err, w_issue, w_kt_last, w_mt_last, w_nt_last, w_final, w_accept;
    logic [AddrWidthC-1:0] w_c_now;

    // Tile counts and the address-space bounds are evaluated on the live size inputs at start
    assign w_mt = M_size_i >> LM;
    assign w_kt = K_size_i >> LK;
    assign w_nt = N_size_i >> LN;
    assign w_mk = PW'(w_mt) * PW'(w_kt);
    assign w_kn = PW'(w_kt) * PW'(w_nt);
    assign w_mn = PW'(w_mt) * PW'(w_nt);
    assign w_size_err = (M_size_i == '0) || (K_size_i == '0) || (N_size_i == '0) ||
                        ((M_size_i & SW'(M - 1)) != '0) || ((K_size_i & SW'(K - 1)) != '0) ||
                        ((N_size_i & SW'(N - 1)) != '0) ||
                        (w_mk > LIM_A) || (w_kn > LIM_A) || (w_mn > LIM_C);

    assign w_accept  = (r_state == S_IDLE) && start_i;
    assign w_issue   = (r_state == S_RUN);
    assign w_kt_last = (r_kt == r_kt_n - SW'(1));
    assign w_mt_last = (r_mt == r_mt_n - SW'(1));
    assign w_nt_last = (r_nt == r_nt_n - SW'(1));
    assign w_final   = w_kt_last && w_mt_last && w_nt_last;
    assign w_c_now   = r_c_row + AddrWidthC'(r_nt);

    assign sram_a_addr_o = r_a_row + AddrWidth'(r_kt);
    assign sram_b_addr_o = r_b_kt + AddrWidth'(r_nt);
    assign sram_c_addr_o = r_c_addr;
    assign sram_c_we_o   = r_c_we;
    assign mac_valid_o   = r_mac_valid;
    assign mac_clear_o   = r_mac_clear;
    assign mac_last_o    = r_mac_last;
    assign busy_o        = (r_state != S_IDLE);
    assign done_o        = (r_state == S_DONE);
    assign err_o         = r_err;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_next = w_size_err ? S_DONE : S_RUN;
            S_RUN:   if (w_final) w_next = S_DRAIN;
            S_DRAIN: if (r_drain) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_mt_n <= '0; r_kt_n <= '0; r_nt_n <= '0;
            r_mt <= '0; r_kt <= '0; r_nt <= '0;
            r_order <= 1'b0; r_drain <= 1'b0; r_err <= 1'b0;
            r_a_row <= '0; r_b_kt <= '0; r_c_row <= '0;
            r_c_pipe <= '0; r_c_addr <= '0;
            r_mac_valid <= 1'b0; r_mac_clear <= 1'b0; r_mac_last <= 1'b0; r_c_we <= 1'b0;
        end else begin
            r_state <= w_next;
            r_drain <= (r_state == S_DRAIN);
            if (w_accept) begin
                r_err   <= w_size_err;
                r_mt_n  <= w_mt;
                r_kt_n  <= w_kt;
                r_nt_n  <= w_nt;
                r_order <= order_i;
                if (!w_size_err) begin
                    r_mt <= '0; r_kt <= '0; r_nt <= '0;
                    r_a_row <= '0; r_b_kt <= '0; r_c_row <= '0;
                end
            end
            // kt innermost; counters freeze on the final pair so addresses hold afterwards
            if (w_issue && !w_final) begin
                if (!w_kt_last) begin
                    r_kt   <= r_kt + SW'(1);
                    r_b_kt <= r_b_kt + AddrWidth'(r_nt_n);
                end else begin
                    r_kt   <= '0;
                    r_b_kt <= '0;
                    if (r_order ? w_mt_last : !w_nt_last) begin
                        r_nt <= r_order ? r_nt + SW'(1) : r_nt + SW'(1);
                        if (r_order) begin
                            r_mt <= '0; r_a_row <= '0; r_c_row <= '0;
                        end
                    end else begin
                        r_mt    <= r_mt + SW'(1);
                        r_a_row <= r_a_row + AddrWidth'(r_kt_n);
                        r_c_row <= r_c_row + AddrWidthC'(r_nt_n);
                        if (!r_order) r_nt <= '0;
                    end
                end
            end
            r_mac_valid <= w_issue;
            r_mac_clear <= w_issue && (r_kt == '0);
            r_mac_last  <= w_issue && w_kt_last;
            if (w_issue && w_kt_last) r_c_pipe <= w_c_now;
            // MAC output register lands one cycle after the last beat
            r_c_we <= r_mac_valid && r_mac_last;
            if (r_mac_valid && r_mac_last) r_c_addr <= r_c_pipe;
        end
    end
endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// tb/tb_gemm_tile_sequencer.sv - directed-vector bench for gemm_tile_sequencer
module tb_gemm_tile_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       order = 1'b0;
    logic [7:0] m_size = '0, k_size = '0, n_size = '0;
    logic [5:0] a_addr, b_addr;
    logic [8:0] c_addr;
    logic       c_we, mac_valid, mac_clear, mac_last, busy, done, err;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int c0 = 0;
    int q_mac_cyc[$], q_mac_a[$], q_mac_b[$], q_mac_cl[$], q_mac_ls[$];
    int q_wr_cyc[$], q_wr_addr[$], q_done[$];
    logic [5:0] prev_a = '0, prev_b = '0;

    gemm_tile_sequencer dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .order_i(order),
        .M_size_i(m_size), .K_size_i(k_size), .N_size_i(n_size),
        .sram_a_addr_o(a_addr), .sram_b_addr_o(b_addr), .sram_c_addr_o(c_addr),
        .sram_c_we_o(c_we), .mac_valid_o(mac_valid), .mac_clear_o(mac_clear),
        .mac_last_o(mac_last), .busy_o(busy), .done_o(done), .err_o(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mac_valid) begin
            q_mac_cyc.push_back(cyc);
            q_mac_a.push_back(int'(prev_a));
            q_mac_b.push_back(int'(prev_b));
            q_mac_cl.push_back(int'(mac_clear));
            q_mac_ls.push_back(int'(mac_last));
        end
        if (c_we) begin
            q_wr_cyc.push_back(cyc);
            q_wr_addr.push_back(int'(c_addr));
        end
        if (done) q_done.push_back(cyc);
        prev_a <= a_addr;
        prev_b <= b_addr;
    end

    task automatic start_job(input int ms, input int ks, input int ns, input bit ord, input bit hold);
        @(negedge clk); #1;
        m_size = 8'(ms); k_size = 8'(ks); n_size = 8'(ns); order = ord;
        start = 1'b1;
        c0 = cyc;
        q_mac_cyc.delete(); q_mac_a.delete(); q_mac_b.delete(); q_mac_cl.delete(); q_mac_ls.delete();
        q_wr_cyc.delete(); q_wr_addr.delete(); q_done.delete();
        @(negedge clk); #1;
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_done(input int count, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (q_done.size() >= count) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset;
        n_vec++;
        if ({a_addr, b_addr, c_addr, c_we, mac_valid, mac_clear, mac_last, busy, done, err} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got a=%0d b=%0d c=%0d we=%b v=%b cl=%b ls=%b busy=%b done=%b err=%b, want all 0",
                     a_addr, b_addr, c_addr, c_we, mac_valid, mac_clear, mac_last, busy, done, err);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_tiled_job(input int ms, input int ks, input int ns, input bit ord,
                                  input int exp_wr, input int exp_done);
        int mtn, ktn, ntn;
        int ea[$], eb[$], ecl[$], els[$], ew[$];
        bit ok;
        mtn = ms / 2; ktn = ks / 32; ntn = ns;
        for (int o = 0; o < (ord ? ntn : mtn); o++)
            for (int in = 0; in < (ord ? mtn : ntn); in++) begin
                int mt, nt;
                mt = ord ? in : o;
                nt = ord ? o : in;
                for (int kt = 0; kt < ktn; kt++) begin
                    ea.push_back(mt * ktn + kt);
                    eb.push_back(kt * ntn + nt);
                    ecl.push_back(kt == 0 ? 1 : 0);
                    els.push_back(kt == ktn - 1 ? 1 : 0);
                end
                ew.push_back(mt * ntn + nt);
            end
        start_job(ms, ks, ns, ord, 1'b0);
        wait_done(1, exp_done + 50, ok);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL job_%0d_%0d_%0d_timeout: no done_o, want done at cycle %0d", ms, ks, ns, exp_done);
        end else if (q_done[0] - c0 !== exp_done) begin
            n_bad++;
            $display("FAIL job_%0d_%0d_%0d_done_cycle: got %0d want %0d", ms, ks, ns, q_done[0] - c0, exp_done);
        end
        n_vec++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL job_%0d_%0d_%0d_err: got %b want 0", ms, ks, ns, err);
        end
        n_vec++;
        if (q_mac_cyc.size() !== ea.size()) begin
            n_bad++;
            $display("FAIL job_%0d_%0d_%0d_beats: got %0d want %0d", ms, ks, ns, q_mac_cyc.size(), ea.size());
        end
        for (int i = 0; i < q_mac_cyc.size() && i < ea.size(); i++) begin
            n_vec++;
            if (q_mac_a[i] !== ea[i] || q_mac_b[i] !== eb[i] || q_mac_cl[i] !== ecl[i] ||
                q_mac_ls[i] !== els[i] || q_mac_cyc[i] - c0 !== 2 + i) begin
                n_bad++;
                $display("FAIL job_%0d_%0d_%0d_beat%0d: got a=%0d b=%0d cl=%0d ls=%0d cyc=%0d want a=%0d b=%0d cl=%0d ls=%0d cyc=%0d",
                         ms, ks, ns, i, q_mac_a[i], q_mac_b[i], q_mac_cl[i], q_mac_ls[i], q_mac_cyc[i] - c0,
                         ea[i], eb[i], ecl[i], els[i], 2 + i);
            end
        end
        n_vec++;
        if (q_wr_cyc.size() !== exp_wr) begin
            n_bad++;
            $display("FAIL job_%0d_%0d_%0d_writes: got %0d want %0d", ms, ks, ns, q_wr_cyc.size(), exp_wr);
        end
        for (int j = 0; j < q_wr_cyc.size() && j < ew.size(); j++) begin
            n_vec++;
            if (q_wr_addr[j] !== ew[j] || q_wr_cyc[j] - c0 !== ktn * (j + 1) + 2) begin
                n_bad++;
                $display("FAIL job_%0d_%0d_%0d_write%0d: got addr=%0d cyc=%0d want addr=%0d cyc=%0d",
                         ms, ks, ns, j, q_wr_addr[j], q_wr_cyc[j] - c0, ew[j], ktn * (j + 1) + 2);
            end
        end
        @(negedge clk); #1;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL job_%0d_%0d_%0d_after: busy=%b done=%b want 0 0", ms, ks, ns, busy, done);
        end
    endtask

    task automatic test_size_error(input int ms, input int ks, input int ns);
        bit ok;
        start_job(ms, ks, ns, 1'b0, 1'b0);
        n_vec++;
        if (done !== 1'b1 || err !== 1'b1) begin
            n_bad++;
            $display("FAIL sizeerr_%0d_%0d_%0d_cycle1: done=%b err=%b want 1 1", ms, ks, ns, done, err);
        end
        wait_done(1, 20, ok);
        repeat (4) @(negedge clk);
        #1;
        n_vec++;
        if (q_mac_cyc.size() !== 0 || q_wr_cyc.size() !== 0 || q_done.size() !== 1) begin
            n_bad++;
            $display("FAIL sizeerr_%0d_%0d_%0d_activity: beats=%0d writes=%0d dones=%0d want 0 0 1",
                     ms, ks, ns, q_mac_cyc.size(), q_wr_cyc.size(), q_done.size());
        end
        n_vec++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL sizeerr_%0d_%0d_%0d_sticky: err=%b busy=%b want 1 0", ms, ks, ns, err, busy);
        end
    endtask

    task automatic test_err_clear;
        bit ok;
        start_job(2, 32, 1, 1'b0, 1'b0);
        n_vec++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL err_clear: err=%b busy=%b want 0 1", err, busy);
        end
        wait_done(1, 20, ok);
        n_vec++;
        if (!ok || q_done[0] - c0 !== 4 || q_wr_cyc.size() !== 1) begin
            n_bad++;
            $display("FAIL err_clear_job: ok=%b writes=%0d want done at 4 with 1 write", ok, q_wr_cyc.size());
        end
    endtask

    task automatic test_reset_mid_run;
        int wr_at_rst;
        start_job(4, 64, 16, 1'b0, 1'b0);
        repeat (19) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        wr_at_rst = q_wr_cyc.size();
        n_vec++;
        if ({a_addr, b_addr, c_addr, c_we, mac_valid, mac_clear, mac_last, busy, done, err} !== '0) begin
            n_bad++;
            $display("FAIL midrun_reset_outputs: a=%0d b=%0d c=%0d we=%b v=%b busy=%b done=%b, want all 0",
                     a_addr, b_addr, c_addr, c_we, mac_valid, busy, done);
        end
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_vec++;
        if (q_wr_cyc.size() !== wr_at_rst || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL midrun_reset_quiet: writes %0d->%0d busy=%b want no change, busy 0",
                     wr_at_rst, q_wr_cyc.size(), busy);
        end
        test_tiled_job(4, 64, 16, 1'b0, 32, 67);
    endtask

    task automatic test_start_held;
        bit ok;
        int deadline;
        start_job(4, 64, 16, 1'b0, 1'b1);
        wait_done(1, 120, ok);
        n_vec++;
        if (!ok || q_done[0] - c0 !== 67 || q_wr_cyc.size() !== 32 || q_mac_cyc.size() !== 64) begin
            n_bad++;
            $display("FAIL held_first_job: ok=%b writes=%0d beats=%0d want done 67, 32 writes, 64 beats",
                     ok, q_wr_cyc.size(), q_mac_cyc.size());
        end
        @(negedge clk); #1;
        n_vec++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL held_idle_gap: busy=%b want 0 at cycle 68", busy);
        end
        deadline = 10;
        while (q_mac_cyc.size() <= 64 && deadline > 0) begin
            @(negedge clk); #1;
            deadline--;
        end
        n_vec++;
        if (q_mac_cyc.size() <= 64) begin
            n_bad++;
            $display("FAIL held_restart_timeout: no beat of second job, want first beat at cycle 70");
        end else if (q_mac_cyc[64] - c0 !== 70 || q_mac_cl[64] !== 1 || q_mac_a[64] !== 0) begin
            n_bad++;
            $display("FAIL held_restart: got cyc=%0d cl=%0d a=%0d want cyc=70 cl=1 a=0",
                     q_mac_cyc[64] - c0, q_mac_cl[64], q_mac_a[64]);
        end
        start = 1'b0;
        wait_done(2, 120, ok);
        n_vec++;
        if (!ok || q_done[1] - c0 !== 135 || q_wr_cyc.size() !== 64) begin
            n_bad++;
            $display("FAIL held_second_job: ok=%b writes=%0d want done at 135 with 64 writes total",
                     ok, q_wr_cyc.size());
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_tiled_job(4, 64, 16, 1'b0, 32, 67);
        test_tiled_job(16, 64, 4, 1'b1, 32, 67);
        test_tiled_job(32, 32, 32, 1'b0, 512, 515);
        test_tiled_job(128, 32, 1, 1'b1, 64, 67);
        test_size_error(3, 32, 1);
        test_err_clear();
        test_size_error(130, 32, 1);
        test_size_error(2, 0, 1);
        test_size_error(2, 48, 1);
        test_reset_mid_run();
        test_start_held();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
